// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, flag and handshake controller turning a 16x5 register file into a FIFO
//
// Drives every control/address input of the external mem register file and
// returns its registered read data to the consumer with a valid strobe.
//
// Optional feature macro: FIFO_CTRL_ERR_EN
//   defined   -> overflow_err / underflow_err are sticky registers cleared by rst
//   undefined -> both error outputs are tied low; rejection behaviour unchanged
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   push, push_data           producer write request and word
//   pop, pop_data, pop_valid  consumer read request, word, valid strobe
//   full, empty               occupancy == DEPTH / == 0
//   almost_full, almost_empty threshold flags on fill_count
//   fill_count                occupancy 0..DEPTH
//   overflow_err              sticky: push rejected
//   underflow_err             sticky: pop rejected
//   write_rq, w_address, write_data   mem write port
//   read_rq, r_address, read_data     mem read port (read_data valid one cycle after read_rq)

module fifo_ctrl #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 5,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fill_count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic              write_rq,
    output logic [ADDR_W-1:0] w_address,
    output logic [DATA_W-1:0] write_data,
    output logic              read_rq,
    output logic [ADDR_W-1:0] r_address,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] ZERO_C  = '0;

    // Pointers carry one extra wrap bit above the mem address.
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] fill_next;
    logic            push_ok;
    logic            pop_ok;

    // Accept decisions use the registered flags of the current cycle, so a
    // push+pop at full rejects the push and at empty rejects the pop.
    assign push_ok = push & ~full  & ~rst;
    assign pop_ok  = pop  & ~empty & ~rst;

    assign fill_next = fill_count
                     + {{ADDR_W{1'b0}}, push_ok}
                     - {{ADDR_W{1'b0}}, pop_ok};

    assign write_rq   = push_ok;
    assign w_address  = wr_ptr[ADDR_W-1:0];
    assign write_data = push_data;
    assign read_rq    = pop_ok;
    assign r_address  = rd_ptr[ADDR_W-1:0];
    assign pop_data   = read_data;

    // Flags are registered from fill_next so they change on the same edge as
    // the pointers, with no extra cycle of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            pop_valid    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + {{ADDR_W{1'b0}}, push_ok};
            rd_ptr       <= rd_ptr + {{ADDR_W{1'b0}}, pop_ok};
            fill_count   <= fill_next;
            full         <= (fill_next == DEPTH_C);
            empty        <= (fill_next == ZERO_C);
            almost_full  <= (fill_next >= AF_C);
            almost_empty <= (fill_next <= AE_C);
            pop_valid    <= pop_ok;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push & full) begin
                overflow_q <= 1'b1;
            end
            if (pop & empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule
